// File: rtl/mup_poll.sv
// Round-robin poller for one shared mup_io instance: walks panels 0..NUM_MUP-1,
// keeps each panel's last good button/analog words and tracks its online state.
module mup_poll #(
    parameter int NUM_MUP  = 8,
    parameter int GAP      = 255,
    parameter int FAIL_LIM = 3
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         enable,
    input  logic [127:0] led_all,
    output logic         start,
    output logic [2:0]   n_mup,
    output logic [15:0]  led,
    input  logic         busy,
    input  logic         error,
    input  logic         answer,
    input  logic [15:0]  but,
    input  logic [23:0]  an_data,
    output logic [127:0] but_all,
    output logic [191:0] an_all,
    output logic [7:0]   online,
    output logic         fail_p,
    output logic         cycle_done
);
    localparam logic [2:0] LAST_IDX = 3'(NUM_MUP - 1);
    localparam logic [9:0] GAP_LAST = 10'(GAP - 1);
    localparam logic [3:0] FLIM     = 4'(FAIL_LIM);

    typedef enum logic [2:0] {
        ST_IDLE, ST_START, ST_W_BUSY, ST_W_DONE, ST_EVAL, ST_GAP
    } state_t;

    state_t state, nxt;
    logic [2:0]       idx;
    logic [9:0]       timer;
    logic             tmo, to_fail, ok;
    logic [3:0]       fc_inc;
    logic [7:0][15:0] led_w, but_r;
    logic [7:0][23:0] an_r;
    logic [7:0][3:0]  fcnt;

    assign led_w   = led_all;
    assign but_all = but_r;
    assign an_all  = an_r;
    // A timed-out transaction can never count as good, whatever mup_io shows.
    assign ok      = !tmo && answer && !error;
    assign fc_inc  = (fcnt[idx] >= FLIM) ? FLIM : fcnt[idx] + 4'd1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= ST_IDLE;
        else        state <= nxt;
    end

    always_comb begin
        nxt     = state;
        start   = 1'b0;
        to_fail = 1'b0;
        case (state)
            ST_IDLE:   if (enable && !busy) nxt = ST_START;
            ST_START: begin
                start = 1'b1;
                nxt   = ST_W_BUSY;
            end
            ST_W_BUSY: begin
                if (busy) nxt = ST_W_DONE;
                else if (timer == 10'd7) begin
                    nxt     = ST_EVAL;
                    to_fail = 1'b1;
                end
            end
            ST_W_DONE: begin
                if (!busy) nxt = ST_EVAL;
                else if (timer == 10'd1022) begin
                    nxt     = ST_EVAL;
                    to_fail = 1'b1;
                end
            end
            ST_EVAL:   nxt = ST_GAP;
            // Expired gap holds off a new start until mup_io is idle.
            ST_GAP: begin
                if (timer >= GAP_LAST) begin
                    if (!enable)   nxt = ST_IDLE;
                    else if (!busy) nxt = ST_START;
                end
            end
            default:   nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx        <= '0;
            timer      <= '0;
            tmo        <= 1'b0;
            n_mup      <= '0;
            led        <= '0;
            but_r      <= '0;
            an_r       <= '0;
            fcnt       <= '0;
            online     <= '0;
            fail_p     <= 1'b0;
            cycle_done <= 1'b0;
        end else begin
            fail_p     <= 1'b0;
            cycle_done <= 1'b0;
            if (nxt != state)         timer <= '0;
            else if (timer != 10'h3ff) timer <= timer + 10'd1;

            if (nxt == ST_START && state != ST_START) begin
                n_mup <= idx;
                led   <= led_w[idx];
                tmo   <= 1'b0;
            end
            if (to_fail) tmo <= 1'b1;

            if (state == ST_EVAL) begin
                if (ok) begin
                    but_r[idx]  <= but;
                    an_r[idx]   <= an_data;
                    fcnt[idx]   <= '0;
                    online[idx] <= 1'b1;
                end else begin
                    fcnt[idx] <= fc_inc;
                    fail_p    <= 1'b1;
                    if (fc_inc == FLIM) online[idx] <= 1'b0;
                end
                cycle_done <= (idx == LAST_IDX);
                idx        <= (idx == LAST_IDX) ? 3'd0 : idx + 3'd1;
            end
        end
    end
endmodule

// File: tb/tb_mup_poll.sv
// Bench for mup_poll: behavioural mup_io responder driven by a per-transaction plan,
// outcomes compared against a per-panel scoreboard at each following start pulse.
module tb_mup_poll;
    localparam int NM = 3, GP = 4, FL = 3, NT = 36;
    localparam int M_OK = 0, M_ERR = 1, M_NOANS = 2, M_SILENT = 3;

    logic         clk = 1'b0, rst_n = 1'b0, enable = 1'b0;
    logic [127:0] led_all;
    logic         start, busy, error, answer, fail_p, cycle_done;
    logic [2:0]   n_mup;
    logic [15:0]  led, but;
    logic [23:0]  an_data;
    logic [127:0] but_all;
    logic [191:0] an_all;
    logic [7:0]   online;

    mup_poll #(.NUM_MUP(NM), .GAP(GP), .FAIL_LIM(FL)) dut (
        .clk(clk), .rst_n(rst_n), .enable(enable), .led_all(led_all),
        .start(start), .n_mup(n_mup), .led(led), .busy(busy), .error(error),
        .answer(answer), .but(but), .an_data(an_data), .but_all(but_all),
        .an_all(an_all), .online(online), .fail_p(fail_p), .cycle_done(cycle_done)
    );

    always #5 clk = ~clk;

    int checks = 0, errors = 0;
    int plan [NT];
    logic [15:0] rsp_but [64];
    logic [23:0] rsp_an  [64];
    int nfail, ncd;

    // scoreboard
    logic [15:0] m_but [NM];
    logic [23:0] m_an  [NM];
    int          m_fc  [NM];
    logic [7:0]  m_on;
    int          m_nfail, m_ncd;

    task automatic chk(input string tag, input logic [191:0] obs, input logic [191:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic wait_start(output bit got, output int w);
        got = 1'b0;
        w   = 0;
        while (!got && w < 200) begin
            @(negedge clk);
            w++;
            got = (start === 1'b1);
        end
        chk("start_seen", 192'(got), 192'(1));
    endtask

    task automatic apply(input int t);
        int p;
        p = t % NM;
        if (plan[t] == M_OK) begin
            m_but[p] = rsp_but[t];
            m_an[p]  = rsp_an[t];
            m_fc[p]  = 0;
            m_on[p]  = 1'b1;
        end else begin
            m_fc[p] = (m_fc[p] + 1 > FL) ? FL : m_fc[p] + 1;
            if (m_fc[p] == FL) m_on[p] = 1'b0;
            m_nfail++;
        end
        if (p == NM - 1) m_ncd++;
    endtask

    task automatic check_model(input string tag);
        logic [127:0] eb;
        logic [191:0] ea;
        eb = '0;
        ea = '0;
        for (int p = 0; p < NM; p++) begin
            eb[p*16 +: 16] = m_but[p];
            ea[p*24 +: 24] = m_an[p];
        end
        chk({tag, "_online"}, 192'(online), 192'(m_on));
        chk({tag, "_but_all"}, 192'(but_all), 192'(eb));
        chk({tag, "_an_all"}, an_all, ea);
        chk({tag, "_fail_p_count"}, 192'(nfail), 192'(m_nfail));
        chk({tag, "_cycle_done_count"}, 192'(ncd), 192'(m_ncd));
    endtask

    always @(negedge clk) begin
        if (!rst_n) begin
            nfail <= 0;
            ncd   <= 0;
        end else begin
            if (fail_p)     nfail <= nfail + 1;
            if (cycle_done) ncd   <= ncd + 1;
        end
    end

    // mup_io stand-in: busy after 0..3 clocks, held 2..5 clocks (6 late in the run)
    int r_t, r_ph, r_dly, r_len, r_p, r_mode;
    logic [15:0] r_but;
    logic [23:0] r_an;
    initial begin
        busy = 0; answer = 0; error = 0; but = 0; an_data = 0;
        r_t = 0; r_ph = 0; r_dly = 0; r_len = 0; r_p = 0; r_mode = M_OK;
        r_but = 0; r_an = 0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                busy = 0; r_ph = 0; r_t = 0;
            end else if (r_ph == 0) begin
                if (start) begin
                    r_p    = int'(n_mup);
                    r_mode = (r_t < NT) ? plan[r_t] : M_OK;
                    r_but  = (r_t < 3) ? 16'hA500 + 16'(r_p) : 16'($urandom);
                    r_an   = (r_t < 3) ? 24'h5A0000 + 24'(r_p) : 24'($urandom);
                    if (r_t < 64) begin
                        rsp_but[r_t] = r_but;
                        rsp_an[r_t]  = r_an;
                    end
                    answer = 0; error = 0;
                    r_dly = $urandom_range(0, 3);
                    r_len = (r_t >= 34) ? 6 : $urandom_range(2, 5);
                    if (r_mode != M_SILENT) begin
                        if (r_dly == 0) begin busy = 1; r_ph = 2; end
                        else r_ph = 1;
                    end
                    r_t++;
                end
            end else if (r_ph == 1) begin
                r_dly--;
                if (r_dly == 0) begin busy = 1; r_ph = 2; end
            end else begin
                r_len--;
                if (r_len == 0) begin
                    chk("hold_n_mup", 192'(n_mup), 192'(r_p));
                    chk("hold_led", 192'(led), 192'(led_all[r_p*16 +: 16]));
                    but = r_but; an_data = r_an;
                    answer = (r_mode != M_NOANS);
                    error  = (r_mode == M_ERR);
                    busy = 0; r_ph = 0;
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        bit got;
        int w, waitc, nstart;
        for (int j = 0; j < NT; j++) plan[j] = M_OK;
        plan[4] = M_ERR; plan[7] = M_ERR; plan[10] = M_ERR; plan[14] = M_SILENT;
        for (int j = 15; j < 34; j++) begin
            int r;
            r = $urandom_range(0, 5);
            plan[j] = (r < 3) ? M_OK : (r == 3) ? M_ERR : (r == 4) ? M_NOANS : M_SILENT;
        end
        for (int p = 0; p < NM; p++) begin m_but[p] = 0; m_an[p] = 0; m_fc[p] = 0; end
        m_on = 0; m_nfail = 0; m_ncd = 0;
        led_all = {$urandom(), $urandom(), $urandom(), $urandom()};
        led_all[47:32] = 16'hBEEF;

        repeat (3) @(negedge clk);
        chk("rst_start", 192'(start), 192'(0));
        chk("rst_n_mup", 192'(n_mup), 192'(0));
        chk("rst_led", 192'(led), 192'(0));
        chk("rst_online", 192'(online), 192'(0));
        chk("rst_fail_p", 192'(fail_p), 192'(0));
        chk("rst_cycle_done", 192'(cycle_done), 192'(0));
        chk("rst_but_all", 192'(but_all), 192'(0));

        rst_n = 1; enable = 1;
        for (int j = 0; j < 35; j++) begin
            wait_start(got, w);
            if (j > 0) begin
                apply(j - 1);
                check_model("seq");
            end
            chk("n_mup", 192'(n_mup), 192'(j % NM));
            chk("led", 192'(led), 192'(led_all[(j % NM)*16 +: 16]));
            if (j == 2)  chk("led_beef", 192'(led), 192'(16'hBEEF));
            if (j == 3) begin
                chk("first_round_but", 192'(but_all[47:0]), 192'(48'hA502_A501_A500));
                chk("first_round_online", 192'(online), 192'(8'b0000_0111));
                chk("first_round_cd", 192'(ncd), 192'(1));
            end
            if (j == 11) begin
                chk("p1_offline", 192'(online[1]), 192'(0));
                chk("p1_slot_kept", 192'(but_all[31:16]), 192'(16'hA501));
                chk("p1_three_fails", 192'(nfail), 192'(3));
            end
            if (j == 14) chk("p1_back_online", 192'(online[1]), 192'(1));
            if (j == 15) chk("silent_period", 192'(w), 192'(1 + 8 + 1 + GP));
        end

        // drop enable while transaction 34 sits in W_DONE
        waitc = 0;
        while (!busy && waitc < 50) begin @(negedge clk); waitc++; end
        chk("busy_seen_34", 192'(busy), 192'(1));
        repeat (2) @(negedge clk);
        enable = 0;
        nstart = 0;
        repeat (40) begin
            @(negedge clk);
            if (start) nstart++;
        end
        chk("no_start_after_disable", 192'(nstart), 192'(0));
        apply(34);
        check_model("disable");

        enable = 1;
        wait_start(got, w);
        chk("restart_from_idle", 192'(w <= 2), 192'(1));
        chk("restart_n_mup", 192'(n_mup), 192'(35 % NM));

        // reset in W_DONE of transaction 35
        waitc = 0;
        while (!busy && waitc < 50) begin @(negedge clk); waitc++; end
        chk("busy_seen_35", 192'(busy), 192'(1));
        repeat (2) @(negedge clk);
        rst_n = 0;
        #1;
        chk("arst_start", 192'(start), 192'(0));
        chk("arst_n_mup", 192'(n_mup), 192'(0));
        chk("arst_led", 192'(led), 192'(0));
        chk("arst_online", 192'(online), 192'(0));
        chk("arst_but_all", 192'(but_all), 192'(0));
        chk("arst_an_all", an_all, 192'(0));
        chk("arst_pulses", 192'({fail_p, cycle_done}), 192'(0));
        repeat (3) @(negedge clk);
        rst_n = 1;
        wait_start(got, w);
        chk("post_rst_n_mup", 192'(n_mup), 192'(0));
        chk("post_rst_led", 192'(led), 192'(led_all[15:0]));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/mup_poll.md
MUP_POLL -- requirements
Module: mup_poll

Interface
REQ-001 Parameter NUM_MUP, default 8: number of panels polled, legal range 1..8, addresses 0..NUM_MUP-1.
REQ-002 Parameter GAP, default 255: idle clocks between the end of one transaction and the next start, legal range 1..1023.
REQ-003 Parameter FAIL_LIM, default 3: consecutive failed transactions before a panel is marked offline, legal range 1..15.
REQ-004 clk  input  1  single clock, same clock as the mup_io instance.
REQ-005 rst_n  input  1  asynchronous, active-low reset.
REQ-006 enable  input  1  high = polling runs; low = polling stops after the current transaction.
REQ-007 led_all  input  128  LED words; panel k uses bits [16k+15:16k].
REQ-008 start  output  1  one-clock start pulse to mup_io.
REQ-009 n_mup  output  3  panel address to mup_io.
REQ-010 led  output  16  LED word to mup_io.
REQ-011 busy, error, answer  input  1 each  status from mup_io.
REQ-012 but  input  16  button word from mup_io.
REQ-013 an_data  input  24  analog word from mup_io.
REQ-014 but_all  output  128  last good button word per panel, slot k = [16k+15:16k].
REQ-015 an_all  output  192  last good analog word per panel, slot k = [24k+23:24k].
REQ-016 online  output  8  per-panel online flag; bits at index >= NUM_MUP are held at 0.
REQ-017 fail_p  output  1  one-clock pulse on each failed transaction.
REQ-018 cycle_done  output  1  one-clock pulse after the panel NUM_MUP-1 transaction is evaluated.

Function
REQ-019 States: IDLE, START, W_BUSY, W_DONE, EVAL, GAP.
REQ-020 IDLE: start=0; when enable=1, go to START on the next clock.
REQ-021 START: assert start for exactly one clock, then go to W_BUSY.
REQ-022 n_mup = current index idx; led = led_all slot idx; both are registered and held constant from START through EVAL.
REQ-023 W_BUSY: go to W_DONE when busy=1; if busy stays 0 for 8 clocks, the transaction is a failure and the FSM goes to EVAL.
REQ-024 W_DONE: go to EVAL when busy=0.
REQ-025 W_DONE watchdog: if busy is still 1 after 1023 clocks in W_DONE, the transaction is a failure and the FSM goes to EVAL.
REQ-026 EVAL success condition: answer=1 and error=0, both sampled in the EVAL clock.
REQ-027 EVAL on success: copy but and an_data into slot idx, clear the fail counter of idx, set online[idx].
REQ-028 EVAL on failure: keep slot idx data unchanged, increment the fail counter of idx (saturates at FAIL_LIM), pulse fail_p.
REQ-029 EVAL on failure, continued: clear online[idx] when the fail counter reaches FAIL_LIM.
REQ-030 EVAL index update: idx wraps to 0 after NUM_MUP-1, otherwise increments by 1; cycle_done pulses when idx was NUM_MUP-1.
REQ-031 EVAL exit: always go to GAP.
REQ-032 GAP: count GAP clocks; at expiry go to START if enable=1, else IDLE.
REQ-033 With NUM_MUP=1, idx stays 0 and cycle_done pulses on every EVAL.
REQ-034 enable falling in any state other than IDLE or GAP: the current transaction completes and is evaluated normally.
REQ-035 enable falling in GAP: the GAP count completes, then the FSM goes to IDLE.
REQ-036 No new start is issued while busy=1.
REQ-037 Fail counters are 4 bits, one per panel.
REQ-038 The W_BUSY and W_DONE timeout counters share one 10-bit counter that clears on every state change.

Reset
REQ-039 rst_n=0 forces, asynchronously: state=IDLE, idx=0, start=0, n_mup=0, led=0, fail_p=0, cycle_done=0.
REQ-040 rst_n=0 also clears, asynchronously: but_all, an_all, online, all fail counters and all timers.
REQ-041 Reset asserted mid-transaction aborts it; no slot update and no pulse occurs; after release polling restarts at panel 0.

Verification
REQ-042 NUM_MUP=3, GAP=4, responder model answers panel k with but=16'hA500+k, an_data=24'h5A0000+k -> but_all slots 0..2 = A500/A501/A502, online=8'b00000111, one cycle_done per 3 EVALs.
REQ-043 led_all slot 2 = 16'hBEEF -> led=16'hBEEF and n_mup=2 held constant from start until busy falls for the panel 2 transaction.
REQ-044 Panel 1 returns error=1 on three consecutive polls (FAIL_LIM=3) -> 3 fail_p pulses, online[1] clears after the 3rd, slot 1 data retains the last good value; the next good poll sets online[1].
REQ-045 busy never rises -> failure declared 8 clocks after start, fail_p pulses, idx advances.
REQ-046 enable dropped during W_DONE -> the transaction is evaluated, GAP runs, FSM reaches IDLE, no further start pulses.
REQ-047 rst_n pulsed low during W_DONE -> all outputs zero immediately; after release the first start carries n_mup=0.
